// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use bubbles, branch
// flushes, multi-cycle EX holds, memory-wait freeze and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_mc_start,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_wait,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_bubble,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

  localparam logic [3:0]       McReload = 4'(MC_LAT - 2);
  localparam logic [CNT_W-1:0] StallMax = '1;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stallCount_q, stallCount_d;

  logic rsMatch;
  logic rtMatch;
  logic loadUse;
  logic mcEnter;
  logic stallCycle;

  // Register $0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign rsMatch = id_uses_rs & (id_rs == ex_rt);
  assign rtMatch = id_uses_rt & (id_rt == ex_rt);
  assign loadUse = ex_mem_read & (ex_rt != 5'd0) & (rsMatch | rtMatch);

  // A taken branch squashes the ID instruction and a load-use stall holds it,
  // so in both cases the multi-cycle op must not be launched yet.
  assign mcEnter = (state_q == RUN) & ~ex_branch_taken & ~loadUse & id_mc_start;

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_wait) begin
      case (state_q)
        RUN: begin
          if (mcEnter) begin
            state_d = MC_BUSY;
            cnt_d   = McReload;
          end
        end
        MC_BUSY: begin
          if (cnt_q == 4'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b1;
    id_ex_bubble = 1'b0;
    mc_busy      = 1'b0;
    if (!rst_n) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (mem_wait) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      id_ex_we = 1'b0;
      mc_busy  = (state_q == MC_BUSY);
    end else if (state_q == MC_BUSY) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      id_ex_we = 1'b0;
      mc_busy  = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (loadUse) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Memory-wait freezes are not counted; only hazard and multi-cycle holds are.
  assign stallCycle = ~mem_wait & ~pc_we;

  always_comb begin
    stallCount_d = stallCount_q;
    if (stallCycle && (stallCount_q != StallMax)) begin
      stallCount_d = stallCount_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      stallCount_q <= '0;
    end else begin
      stallCount_q <= stallCount_d;
    end
  end

  assign stall_count = stallCount_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic,
// compared against a remaining-busy-cycles reference model.
module tb_pipe_hazard_ctrl;

  localparam int MC_LAT  = 4;
  localparam int CNT_W   = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b1;
  logic             rst_n;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rs, id_uses_rt, id_mc_start;
  logic             ex_mem_read, ex_branch_taken, mem_wait;
  logic             pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, mc_busy;
  logic [CNT_W-1:0] stall_count;

  int compared   = 0;
  int mismatched = 0;

  int               mBusyLeft = 0;
  int               mStall    = 0;
  logic [5:0]       expCtl;
  logic [CNT_W-1:0] expStall;

  pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mc_start(id_mc_start), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble), .mc_busy(mc_busy),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obsCtl();
    return {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, mc_busy};
  endfunction

  function automatic logic modelLu();
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
  endfunction

  // Expected {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, mc_busy}.
  function automatic logic [5:0] modelCtl();
    if (!rst_n)          return 6'b001010;
    if (mem_wait)        return {5'b00000, mBusyLeft > 0};
    if (mBusyLeft > 0)   return 6'b000001;
    if (ex_branch_taken) return 6'b111110;
    if (modelLu())       return 6'b000110;
    return 6'b110100;
  endfunction

  task automatic modelEdge();
    logic [5:0] ctl;
    ctl = modelCtl();
    if (!rst_n) begin
      mBusyLeft = 0;
      mStall    = 0;
    end else if (!mem_wait) begin
      if (!ctl[5] && mStall < STALL_MAX) mStall++;
      if (mBusyLeft > 0) mBusyLeft--;
      else if (!ex_branch_taken && !modelLu() && id_mc_start) mBusyLeft = MC_LAT - 1;
    end
  endtask

  // Inputs change just after the active (falling) edge; outputs are sampled on the rising edge.
  task automatic applyStimulus(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic mcs,
                               input logic [4:0] exrt, input logic mr, input logic bt,
                               input logic mw);
    @(negedge clk);
    modelEdge();
    #1;
    rst_n = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_mc_start = mcs; ex_rt = exrt; ex_mem_read = mr; ex_branch_taken = bt; mem_wait = mw;
    @(posedge clk);
    expCtl   = modelCtl();
    expStall = CNT_W'(mStall);
  endtask

  task automatic applyIdle();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
      compared++;
      if (obsCtl() !== expCtl) begin
        mismatched++;
        $display("[TB] FAIL reset_ctl: got %b expected %b", obsCtl(), expCtl);
      end
      compared++;
      if (stall_count !== expStall) begin
        mismatched++;
        $display("[TB] FAIL reset_stall: got %0d expected %0d", stall_count, expStall);
      end
    end
    applyIdle();
    compared++;
    if (obsCtl() !== 6'b110100) begin
      mismatched++;
      $display("[TB] FAIL reset_release_ctl: got %b expected %b", obsCtl(), 6'b110100);
    end
  endtask

  task automatic test_load_use();
    applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    compared++;
    if (obsCtl() !== expCtl) begin
      mismatched++;
      $display("[TB] FAIL lu_rs_ctl: got %b expected %b", obsCtl(), expCtl);
    end
    applyIdle();
    compared++;
    if (obsCtl() !== expCtl || stall_count !== expStall) begin
      mismatched++;
      $display("[TB] FAIL lu_clear: got %b/%0d expected %b/%0d", obsCtl(), stall_count, expCtl, expStall);
    end
    applyStimulus(1'b1, 5'd9, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    compared++;
    if (obsCtl() !== expCtl) begin
      mismatched++;
      $display("[TB] FAIL lu_rt_ctl: got %b expected %b", obsCtl(), expCtl);
    end
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    compared++;
    if (obsCtl() !== expCtl) begin
      mismatched++;
      $display("[TB] FAIL lu_r0_ctl: got %b expected %b", obsCtl(), expCtl);
    end
    applyIdle();
    compared++;
    if (stall_count !== expStall) begin
      mismatched++;
      $display("[TB] FAIL lu_stall: got %0d expected %0d", stall_count, expStall);
    end
  endtask

  task automatic test_multicycle();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    compared++;
    if (obsCtl() !== expCtl) begin
      mismatched++;
      $display("[TB] FAIL mc_entry_ctl: got %b expected %b", obsCtl(), expCtl);
    end
    for (int i = 0; i < MC_LAT - 1; i++) begin
      applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, (i == 1), 1'b0);
      compared++;
      if (obsCtl() !== expCtl) begin
        mismatched++;
        $display("[TB] FAIL mc_busy_ctl[%0d]: got %b expected %b", i, obsCtl(), expCtl);
      end
    end
    applyIdle();
    compared++;
    if (obsCtl() !== expCtl || stall_count !== expStall) begin
      mismatched++;
      $display("[TB] FAIL mc_exit: got %b/%0d expected %b/%0d", obsCtl(), stall_count, expCtl, expStall);
    end
  endtask

  task automatic test_branch_vs_lu();
    applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    compared++;
    if (obsCtl() !== expCtl) begin
      mismatched++;
      $display("[TB] FAIL branch_lu_ctl: got %b expected %b", obsCtl(), expCtl);
    end
    applyIdle();
    compared++;
    if (obsCtl() !== expCtl || stall_count !== expStall) begin
      mismatched++;
      $display("[TB] FAIL branch_lu_after: got %b/%0d expected %b/%0d", obsCtl(), stall_count, expCtl, expStall);
    end
  endtask

  task automatic test_mem_wait();
    logic mwSeq [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, (i == 0), 5'd0, 1'b0, 1'b0, mwSeq[i]);
      compared++;
      if (obsCtl() !== expCtl || stall_count !== expStall) begin
        mismatched++;
        $display("[TB] FAIL mw_mc[%0d]: got %b/%0d expected %b/%0d", i, obsCtl(), stall_count, expCtl, expStall);
      end
    end
    applyStimulus(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1);
    compared++;
    if (obsCtl() !== expCtl) begin
      mismatched++;
      $display("[TB] FAIL mw_branch_ctl: got %b expected %b", obsCtl(), expCtl);
    end
    applyStimulus(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    compared++;
    if (obsCtl() !== expCtl || stall_count !== expStall) begin
      mismatched++;
      $display("[TB] FAIL mw_lu_reeval: got %b/%0d expected %b/%0d", obsCtl(), stall_count, expCtl, expStall);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2 * MC_LAT + 1; i++) begin
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      compared++;
      if (obsCtl() !== expCtl || stall_count !== expStall) begin
        mismatched++;
        $display("[TB] FAIL b2b_mc[%0d]: got %b/%0d expected %b/%0d", i, obsCtl(), stall_count, expCtl, expStall);
      end
    end
  endtask

  task automatic test_reset_abort();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    applyIdle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    applyIdle();
    compared++;
    if (obsCtl() !== 6'b110100 || stall_count !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_abort: got %b/%0d expected %b/0", obsCtl(), stall_count, 6'b110100);
    end
  endtask

  task automatic test_saturation();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
      compared++;
      if (obsCtl() !== expCtl || stall_count !== expStall) begin
        mismatched++;
        $display("[TB] FAIL sat[%0d]: got %b/%0d expected %b/%0d", i, obsCtl(), stall_count, expCtl, expStall);
      end
    end
    applyIdle();
    compared++;
    if (stall_count !== CNT_W'(STALL_MAX)) begin
      mismatched++;
      $display("[TB] FAIL sat_final: got %0d expected %0d", stall_count, STALL_MAX);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 31) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                    5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 5) == 0));
      compared++;
      if (obsCtl() !== expCtl || stall_count !== expStall) begin
        mismatched++;
        $display("[TB] FAIL rand[%0d]: got %b/%0d expected %b/%0d", i, obsCtl(), stall_count, expCtl, expStall);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_mc_start = 1'b0; ex_rt = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b1; mem_wait = 1'b0;
    test_reset();
    test_load_use();
    test_multicycle();
    test_branch_vs_lu();
    test_mem_wait();
    test_back_to_back();
    test_reset_abort();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
